// File: rtl/fir_filter.sv
// Single-multiplier time-multiplexed FIR filter with AXI-Stream style handshakes.
// One sample is accepted, then NTAPS multiply-accumulate cycles, then one output cycle.
module fir_filter #(
   parameter int                  NTAPS = 16,
   parameter logic [16*NTAPS-1:0] COEF  = {NTAPS{16'h0800}}
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        s_axis_data_tvalid,
   input  logic [15:0] s_axis_data_tdata,
   output logic        s_axis_data_tready,
   output logic        m_axis_data_tvalid,
   output logic [15:0] m_axis_data_tdata
);

   localparam int KW   = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam int ACCW = 33 + $clog2(NTAPS);

   localparam logic signed [ACCW-1:0] SAT_MAX   = ACCW'(32'sd32767);
   localparam logic signed [ACCW-1:0] SAT_MIN   = ACCW'(-32'sd32768);
   localparam logic signed [ACCW-1:0] ROUND_INC = ACCW'(32'sd16384);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                  state;
   logic [KW-1:0]           tap;
   logic signed [15:0]      dline    [NTAPS];
   logic signed [15:0]      coef_tab [NTAPS];
   logic signed [31:0]      product;
   logic signed [ACCW-1:0]  acc;
   logic                    accept;

   // Round half up from Q1.15 products back to 16 bits, clamping to the sample range.
   function automatic logic signed [15:0] scale_sat(input logic signed [ACCW-1:0] a);
      logic signed [ACCW-1:0] r;
      r = (a + ROUND_INC) >>> 5'd15;
      if (r > SAT_MAX) begin
         scale_sat = 16'sh7FFF;
      end else if (r < SAT_MIN) begin
         scale_sat = 16'sh8000;
      end else begin
         scale_sat = r[15:0];
      end
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NTAPS; gi++) begin : g_coef
         assign coef_tab[gi] = COEF[16*gi +: 16];
      end
   endgenerate

   // tready is only ever high in IDLE, so this is the full acceptance condition.
   assign accept = s_axis_data_tvalid & s_axis_data_tready;

   // Shared multiplier: the tap counter selects coefficient and delayed sample.
   always_comb begin
      product = coef_tab[tap] * dline[tap];
   end

   // Delay line: newest sample at position 0, shifted on every acceptance.
   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < NTAPS; i++) begin
            dline[i] <= 16'sd0;
         end
      end else if (accept) begin
         dline[0] <= s_axis_data_tdata;
         for (int i = 1; i < NTAPS; i++) begin
            dline[i] <= dline[i-1];
         end
      end
   end

   // Accumulator: cleared on entry to MAC, one product added per MAC cycle.
   always_ff @(posedge aclk) begin
      if (areset) begin
         acc <= '0;
      end else if (accept) begin
         acc <= '0;
      end else if (state == MAC) begin
         acc <= acc + ACCW'(product);
      end
   end

   // Control FSM with registered handshake and output signals.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state              <= IDLE;
         tap                <= '0;
         s_axis_data_tready <= 1'b0;
         m_axis_data_tvalid <= 1'b0;
         m_axis_data_tdata  <= 16'd0;
      end else begin
         m_axis_data_tvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state              <= MAC;
                  tap                <= '0;
                  s_axis_data_tready <= 1'b0;
               end else begin
                  s_axis_data_tready <= 1'b1;
               end
            end
            MAC: begin
               s_axis_data_tready <= 1'b0;
               if (tap == KW'(NTAPS - 1)) begin
                  state <= OUT;
               end else begin
                  tap <= tap + KW'(1);
               end
            end
            OUT: begin
               m_axis_data_tdata  <= scale_sat(acc);
               m_axis_data_tvalid <= 1'b1;
               s_axis_data_tready <= 1'b1;
               state              <= IDLE;
            end
            default: begin
               state              <= IDLE;
               s_axis_data_tready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_filter.sv
// Bench for fir_filter: a unity-gain instance and a saturating instance share one
// input stream and are compared against a sum-of-products reference model.
module tb_fir_filter;

   localparam int NT = 16;

   logic        aclk = 1'b0;
   logic        areset;
   logic        s_tvalid;
   logic [15:0] s_tdata;
   logic        tready1, mv1, tready2, mv2;
   logic [15:0] md1, md2;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   int  hist [NT];
   int  q_cyc[$];
   int  q_y1[$];
   int  q_y2[$];
   int  got1[$];
   int  got2[$];
   bit  acc_flag;
   int  acc_edge;

   always #5 aclk = ~aclk;

   always @(posedge aclk) cyc <= cyc + 1;

   fir_filter #(.NTAPS(NT)) dut (
      .aclk(aclk), .areset(areset),
      .s_axis_data_tvalid(s_tvalid), .s_axis_data_tdata(s_tdata),
      .s_axis_data_tready(tready1),
      .m_axis_data_tvalid(mv1), .m_axis_data_tdata(md1)
   );

   fir_filter #(.NTAPS(NT), .COEF({NT{16'h7FFF}})) dut_sat (
      .aclk(aclk), .areset(areset),
      .s_axis_data_tvalid(s_tvalid), .s_axis_data_tdata(s_tdata),
      .s_axis_data_tready(tready2),
      .m_axis_data_tvalid(mv2), .m_axis_data_tdata(md2)
   );

   task automatic chk(input string tag, input longint obs, input longint expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Reference: plain convolution with equal taps h, round half up, clamp.
   function automatic int ref_out(input int h);
      longint s;
      s = 0;
      for (int k = 0; k < NT; k++) s += longint'(h) * longint'(hist[k]);
      s = (s + 64'sd16384) >>> 15;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return int'(s);
   endfunction

   // One clock: drive at negedge, update the model, then check the outputs at the next negedge.
   task automatic cycle(input bit v, input logic [15:0] d);
      bit take;
      s_tvalid = v;
      s_tdata  = d;
      take = v && (tready1 === 1'b1) && !areset;
      @(posedge aclk);
      @(negedge aclk);
      acc_flag = take;
      if (areset) begin
         for (int k = 0; k < NT; k++) hist[k] = 0;
         q_cyc.delete(); q_y1.delete(); q_y2.delete();
      end else if (take) begin
         for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0]  = int'($signed(d));
         acc_edge = cyc;
         q_cyc.push_back(cyc + NT + 1);
         q_y1.push_back(ref_out(2048));
         q_y2.push_back(ref_out(32767));
      end
      chk("tvalid_pair", mv2, mv1);
      chk("tready_pair", tready2, tready1);
      if (mv1 === 1'b1) begin
         if (q_cyc.size() == 0) begin
            chk("spurious_pulse", mv1, 0);
         end else begin
            chk("latency", cyc, q_cyc[0]);
            chk("y_unity", $signed(md1), q_y1[0]);
            chk("y_sat", $signed(md2), q_y2[0]);
            got1.push_back(int'($signed(md1)));
            got2.push_back(int'($signed(md2)));
            void'(q_cyc.pop_front()); void'(q_y1.pop_front()); void'(q_y2.pop_front());
         end
      end else if (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
         chk("missing_pulse", mv1, 1);
         void'(q_cyc.pop_front()); void'(q_y1.pop_front()); void'(q_y2.pop_front());
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (tready1 !== 1'b1 && n < 40) begin
         cycle(1'b0, 16'd0);
         n++;
      end
      chk("ready_timeout", tready1, 1);
   endtask

   task automatic send(input logic [15:0] d);
      wait_ready();
      cycle(1'b1, d);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q_cyc.size() > 0 && n < 60) begin
         cycle(1'b0, 16'd0);
         n++;
      end
      chk("drain", q_cyc.size(), 0);
      repeat (3) cycle(1'b0, 16'd0);
   endtask

   task automatic do_reset(input int n);
      areset = 1'b1;
      cycle(1'b0, 16'd0);
      chk("rst_tready", tready1, 0);
      chk("rst_mvalid", mv1, 0);
      chk("rst_mdata", md1, 0);
      repeat (n - 1) cycle(1'b0, 16'd0);
      areset = 1'b0;
      cycle(1'b0, 16'd0);
      chk("tready_after_rst", tready1, 1);
      got1.delete();
      got2.delete();
   endtask

   initial begin
      int prev, n_acc;
      longint e;
      int smp [4];
      int rexp[4];
      areset   = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = 16'd0;
      for (int k = 0; k < NT; k++) hist[k] = 0;
      @(negedge aclk);

      do_reset(3);

      // Impulse 16384: sixteen outputs of 1024, then zeros.
      send(16'd16384);
      repeat (20) send(16'd0);
      drain();
      chk("impulse_count", got1.size(), 21);
      for (int i = 0; i < 21 && i < got1.size(); i++)
         chk("impulse_resp", got1[i], (i < 16) ? 1024 : 0);

      // Constant full-scale step through unity-gain filter.
      do_reset(2);
      repeat (20) send(16'd32767);
      drain();
      chk("step_count", got1.size(), 20);
      for (int k = 1; k <= 20 && k <= got1.size(); k++) begin
         e = (k >= 16) ? 64'sd32767 : ((longint'(k) * 32767 * 2048 + 16384) >>> 15);
         chk("step_resp", got1[k-1], e);
      end
      for (int k = 2; k <= got2.size(); k++) chk("sat_pos", got2[k-1], 32767);

      // Constant most-negative input.
      do_reset(2);
      repeat (6) send(16'h8000);
      drain();
      chk("neg_count", got2.size(), 6);
      for (int k = 2; k <= got2.size(); k++) chk("sat_neg", got2[k-1], -32768);

      // Negative impulse.
      do_reset(2);
      send(16'hC000);
      repeat (16) send(16'd0);
      drain();
      chk("neg_imp_count", got1.size(), 17);
      for (int i = 0; i < got1.size(); i++)
         chk("neg_impulse", got1[i], (i < 16) ? -1024 : 0);

      // Rounding around half-LSB points.
      smp  = '{1, 8, -8, -9};
      rexp = '{0, 1, 0, -1};
      for (int i = 0; i < 4; i++) begin
         do_reset(2);
         send(16'(smp[i]));
         drain();
         chk("round_count", got1.size(), 1);
         if (got1.size() > 0) chk("rounding", got1[0], rexp[i]);
      end

      // Reset in the middle of MAC discards everything.
      do_reset(2);
      send(16'd12345);
      repeat (5) cycle(1'b0, 16'd0);
      do_reset(2);
      repeat (25) cycle(1'b0, 16'd0);
      chk("no_pulse_after_abort", got1.size(), 0);
      send(16'd16384);
      drain();
      chk("post_abort_count", got1.size(), 1);
      if (got1.size() > 0) chk("post_abort_y", got1[0], 1024);

      // tvalid held high: one acceptance every NT+2 cycles, other data ignored.
      do_reset(2);
      prev  = -1;
      n_acc = 0;
      for (int i = 0; i < (NT + 2) * 6; i++) begin
         cycle(1'b1, 16'($urandom));
         if (acc_flag) begin
            n_acc++;
            if (prev >= 0) chk("ready_period", acc_edge - prev, NT + 2);
            prev = acc_edge;
         end
      end
      chk("accept_count", n_acc, 6);
      drain();

      // Random samples with random idle gaps.
      do_reset(2);
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 3)) cycle(1'b0, 16'd0);
         send(16'($urandom));
      end
      drain();
      chk("random_count", got1.size(), 30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
